regfile_max_scanner: RTL and testbench
======================================

REGFILE_MAX_SCANNER -- requirements
Module: regfile_max_scanner

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, register data width, signed two's complement.
REQ-003 SHALL have parameter REG_COUNT, default 32, number of register-file entries (2**ADDR_WIDTH).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  scan request, sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate scan, no done pulse.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  first entry to scan.
REQ-009 SHALL have port count  input  ADDR_WIDTH+1  number of entries to scan, 0..REG_COUNT.
REQ-010 SHALL have port rd_addrA  output  ADDR_WIDTH  register-file read address, port A.
REQ-011 SHALL have port rd_addrB  output  ADDR_WIDTH  register-file read address, port B.
REQ-012 SHALL have port rd_dataA  input  DATA_WIDTH  combinational read data for rd_addrA.
REQ-013 SHALL have port rd_dataB  input  DATA_WIDTH  combinational read data for rd_addrB.
REQ-014 SHALL have port busy  output  1  high in SCAN.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port valid  output  1  result holds a scanned entry (count>0).
REQ-017 SHALL have port max_data  output  DATA_WIDTH  largest signed value found.
REQ-018 SHALL have port max_addr  output  ADDR_WIDTH  address of max_data.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN, DONE; IDLE->SCAN on start with count>0; IDLE->DONE on start with count=0; SCAN->DONE when remaining reaches 0; DONE->IDLE unconditionally.
REQ-020 SHALL on start latch cur=base_addr and remaining=count, and clear valid.
REQ-021 SHALL in SCAN drive rd_addrA=cur and rd_addrB=cur+1 (mod REG_COUNT) from registers; outside SCAN drive both to 0.
REQ-022 SHALL in each SCAN cycle sample rd_dataA, plus rd_dataB only when remaining>=2, then advance cur by 2 (mod REG_COUNT) and decrement remaining by 2 (saturating at 0).
REQ-023 SHALL initialise best from the first sampled entry, then replace best only on a strictly greater signed value; ties keep the entry earlier in scan order (A before B, earlier cycle before later).
REQ-024 SHALL complete a scan in ceil(count/2) SCAN cycles followed by one DONE cycle, done=1 only in DONE.
REQ-025 SHALL wrap addresses past REG_COUNT-1 to 0 (e.g. base 31, count 3 scans 31,0,1).
REQ-026 SHALL with count=0 pulse done with valid=0, max_data=0, max_addr=0.
REQ-027 SHALL treat count>REG_COUNT as REG_COUNT.
REQ-028 SHALL ignore start while in SCAN or DONE.
REQ-029 SHALL on abort in SCAN return to IDLE next cycle, no done, valid=0; abort takes priority over completion in the same cycle.
REQ-030 SHALL hold max_data, max_addr, valid stable from DONE until the next accepted start.

Reset
REQ-031 SHALL on nrst=0 at a rising edge force IDLE, and set busy, done, valid, max_data, max_addr, rd_addrA, rd_addrB, cur, remaining to 0, including mid-scan.
REQ-032 SHALL give nrst priority over start and abort.

Structure
REQ-033 SHALL place the FSM state enum and default width constants in a shared package, regfile_pkg.
REQ-034 SHALL use one sub-module, max_pair_cmp: combinational signed compare of (best, A, B, enables) returning new best value/address with tie rule of REQ-023.

Verification
REQ-035 SHALL test: regs[i]=i*3, base 0, count 32 -> 16 busy cycles, done, max_data=93, max_addr=31, valid=1.
REQ-036 SHALL test: regs[4]=regs[9]=0x0100, others 0x0010, base 0, count 32 -> max_addr=4 (tie rule).
REQ-037 SHALL test: regs[30]=-5, regs[31]=-2, regs[0]=-7, base 30, count 3 -> 2 busy cycles, max_data=-2, max_addr=31.
REQ-038 SHALL test: start with count=0 -> done one cycle later, valid=0, max_data=0.
REQ-039 SHALL test: abort at SCAN cycle 3 of count-32 scan, then nrst low mid-second-scan -> no done pulse, all outputs 0, FSM IDLE.
REQ-040 SHALL test: start held high during SCAN -> exactly one done per accepted start.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file maximum scanner: FSM encoding
// and default geometry.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_REG_COUNT  = 32;

endpackage

// File: rtl/regfile_max_scanner_if.sv
// Scanner bundle: request/result signals plus the dual combinational
// register-file read port.
interface regfile_max_scanner_if
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                         start;
    logic                         abort;
    logic        [ADDR_WIDTH-1:0] base_addr;
    logic        [ADDR_WIDTH:0]   count;
    logic        [ADDR_WIDTH-1:0] rd_addrA;
    logic        [ADDR_WIDTH-1:0] rd_addrB;
    logic signed [DATA_WIDTH-1:0] rd_dataA;
    logic signed [DATA_WIDTH-1:0] rd_dataB;
    logic                         busy;
    logic                         done;
    logic                         valid;
    logic signed [DATA_WIDTH-1:0] max_data;
    logic        [ADDR_WIDTH-1:0] max_addr;

    // The scanner itself.
    modport slave (
        input  start, abort, base_addr, count, rd_dataA, rd_dataB,
        output rd_addrA, rd_addrB, busy, done, valid, max_data, max_addr
    );

    // Requester together with the register file it reads.
    modport master (
        output start, abort, base_addr, count, rd_dataA, rd_dataB,
        input  rd_addrA, rd_addrB, busy, done, valid, max_data, max_addr
    );
endinterface

// File: rtl/regfile_max_scanner_cmp.sv
// Combinational best-of-three: running best against up to two new entries,
// keeping the earliest entry on equal values.
module max_pair_cmp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] best_data,
    input  logic        [ADDR_WIDTH-1:0] best_addr,
    input  logic                         best_vld,
    input  logic signed [DATA_WIDTH-1:0] a_data,
    input  logic        [ADDR_WIDTH-1:0] a_addr,
    input  logic                         a_en,
    input  logic signed [DATA_WIDTH-1:0] b_data,
    input  logic        [ADDR_WIDTH-1:0] b_addr,
    input  logic                         b_en,
    output logic signed [DATA_WIDTH-1:0] new_data,
    output logic        [ADDR_WIDTH-1:0] new_addr
);
    logic have;

    // Strict '>' is what gives earlier entries priority on ties.
    always_comb begin
        new_data = best_data;
        new_addr = best_addr;
        have     = best_vld;
        if (a_en && (!have || a_data > new_data)) begin
            new_data = a_data;
            new_addr = a_addr;
            have     = 1'b1;
        end
        if (b_en && (!have || b_data > new_data)) begin
            new_data = b_data;
            new_addr = b_addr;
        end
    end
endmodule

// File: rtl/regfile_max_scanner.sv
// Scans a window of the register file two entries per cycle and reports the
// largest signed value and its address.
module regfile_max_scanner
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REG_COUNT  = DEF_REG_COUNT
) (
    input  logic                  clk,
    input  logic                  nrst,
    regfile_max_scanner_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(REG_COUNT);
    localparam logic [ADDR_WIDTH:0] TWO     = (ADDR_WIDTH+1)'(2);

    scan_state_t                  state, state_nxt;
    logic        [ADDR_WIDTH-1:0] cur, cur_b;
    logic        [ADDR_WIDTH:0]   remaining, count_eff;
    logic signed [DATA_WIDTH-1:0] best_data, cmp_data;
    logic        [ADDR_WIDTH-1:0] best_addr, cmp_addr;
    logic                         best_vld;
    logic                         en_b, last;

    always_comb begin
        count_eff = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;
        en_b      = (remaining >= TWO);
        last      = (remaining <= TWO);
    end

    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Abort is checked before completion so a last-cycle abort never pulses done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (count_eff == '0) ? DONE : SCAN;
            SCAN: begin
                if (bus.abort) state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    max_pair_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .best_data (best_data),
        .best_addr (best_addr),
        .best_vld  (best_vld),
        .a_data    (bus.rd_dataA),
        .a_addr    (cur),
        .a_en      (1'b1),
        .b_data    (bus.rd_dataB),
        .b_addr    (cur_b),
        .b_en      (en_b),
        .new_data  (cmp_data),
        .new_addr  (cmp_addr)
    );

    // cur_b tracks cur+1 so both read addresses come straight from flops.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cur       <= '0;
            cur_b     <= '0;
            remaining <= '0;
            best_data <= '0;
            best_addr <= '0;
            best_vld  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cur       <= bus.base_addr;
                    cur_b     <= bus.base_addr + ADDR_WIDTH'(1);
                    remaining <= count_eff;
                    best_data <= '0;
                    best_addr <= '0;
                    best_vld  <= 1'b0;
                end
                SCAN: begin
                    if (bus.abort) begin
                        remaining <= '0;
                        best_vld  <= 1'b0;
                    end else begin
                        cur       <= cur + ADDR_WIDTH'(2);
                        cur_b     <= cur_b + ADDR_WIDTH'(2);
                        remaining <= en_b ? (remaining - TWO) : '0;
                        best_data <= cmp_data;
                        best_addr <= cmp_addr;
                        best_vld  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_addrA = (state == SCAN) ? cur   : '0;
    assign bus.rd_addrB = (state == SCAN) ? cur_b : '0;
    assign bus.busy     = (state == SCAN);
    assign bus.done     = (state == DONE);
    assign bus.valid    = best_vld;
    assign bus.max_data = best_data;
    assign bus.max_addr = best_addr;
endmodule

// File: tb/tb_regfile_max_scanner.sv
// Directed bench for regfile_max_scanner with a behavioural register file
// and hand-computed expected results.
module tb_regfile_max_scanner;
    import regfile_pkg::*;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int RC = 32;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    regfile_max_scanner_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic signed [DW-1:0] regs [RC];
    assign bus.rd_dataA = regs[bus.rd_addrA];
    assign bus.rd_dataB = regs[bus.rd_addrB];

    regfile_max_scanner #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .REG_COUNT  (RC)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int nbusy, ndone;

    task automatic check_vec(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_all(input int v);
        for (int i = 0; i < RC; i++) regs[i] = DW'(v);
    endtask

    // Start a scan and follow it to the DONE cycle; returns there (sampled on negedge).
    task automatic run_scan(input int base, input int cnt, output int nb, output int nd);
        @(negedge clk);
        bus.base_addr = AW'(base);
        bus.count     = (AW+1)'(cnt);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0;
        for (int t = 0; t < 200 && !bus.done; t++) begin
            if (bus.busy) nb++;
            @(negedge clk);
        end
        nd = bus.done ? 1 : 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_vec({tag, "_busy"},  int'(bus.busy),     0);
        check_vec({tag, "_done"},  int'(bus.done),     0);
        check_vec({tag, "_valid"}, int'(bus.valid),    0);
        check_vec({tag, "_data"},  int'(bus.max_data), 0);
        check_vec({tag, "_addr"},  int'(bus.max_addr), 0);
        check_vec({tag, "_rdA"},   int'(bus.rd_addrA), 0);
        check_vec({tag, "_rdB"},   int'(bus.rd_addrB), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.count = '0;
        for (int i = 0; i < RC; i++) regs[i] = DW'(i * 3);
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        nrst = 1'b1;

        // Ramp: max is the last entry.
        run_scan(0, 32, nbusy, ndone);
        check_vec("ramp_done",  ndone, 1);
        check_vec("ramp_busy",  nbusy, 16);
        check_vec("ramp_data",  int'(bus.max_data), 93);
        check_vec("ramp_addr",  int'(bus.max_addr), 31);
        check_vec("ramp_valid", int'(bus.valid), 1);
        @(negedge clk);
        check_vec("ramp_done_width", int'(bus.done), 0);
        check_vec("ramp_hold_data",  int'(bus.max_data), 93);
        check_vec("ramp_hold_valid", int'(bus.valid), 1);

        // Oversized count clamps to the full file.
        run_scan(0, 40, nbusy, ndone);
        check_vec("clamp_busy", nbusy, 16);
        check_vec("clamp_data", int'(bus.max_data), 93);

        // Tie between entries 4 and 9: earlier one wins.
        fill_all(16'h0010);
        regs[4] = 16'h0100;
        regs[9] = 16'h0100;
        run_scan(0, 32, nbusy, ndone);
        check_vec("tie_done", ndone, 1);
        check_vec("tie_data", int'(bus.max_data), 256);
        check_vec("tie_addr", int'(bus.max_addr), 4);

        // Negative values with wrap; regs[1] must not be sampled.
        fill_all(100);
        regs[30] = -16'sd5;
        regs[31] = -16'sd2;
        regs[0]  = -16'sd7;
        @(negedge clk);
        bus.base_addr = AW'(30); bus.count = 6'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_vec("wrap_rdA_c1", int'(bus.rd_addrA), 30);
        check_vec("wrap_rdB_c1", int'(bus.rd_addrB), 31);
        @(negedge clk);
        check_vec("wrap_rdA_c2", int'(bus.rd_addrA), 0);
        check_vec("wrap_rdB_c2", int'(bus.rd_addrB), 1);
        @(negedge clk);
        check_vec("wrap_done", int'(bus.done), 1);
        check_vec("wrap_data", int'(bus.max_data), -2);
        check_vec("wrap_addr", int'(bus.max_addr), 31);
        run_scan(30, 3, nbusy, ndone);
        check_vec("neg_busy", nbusy, 2);
        check_vec("neg_data", int'(bus.max_data), -2);

        // Empty scan clears the previous result.
        run_scan(5, 0, nbusy, ndone);
        check_vec("empty_done",  ndone, 1);
        check_vec("empty_busy",  nbusy, 0);
        check_vec("empty_valid", int'(bus.valid), 0);
        check_vec("empty_data",  int'(bus.max_data), 0);
        check_vec("empty_addr",  int'(bus.max_addr), 0);

        // Abort in the third SCAN cycle.
        for (int i = 0; i < RC; i++) regs[i] = DW'(i * 3);
        @(negedge clk);
        bus.base_addr = '0; bus.count = 6'd32; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_vec("abort_busy",  int'(bus.busy), 0);
        check_vec("abort_valid", int'(bus.valid), 0);
        ndone = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        check_vec("abort_no_done", ndone, 0);

        // Abort in the final SCAN cycle beats completion.
        @(negedge clk);
        bus.base_addr = '0; bus.count = 6'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_vec("abort_last_done", int'(bus.done), 0);
        check_vec("abort_last_busy", int'(bus.busy), 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.base_addr = '0; bus.count = 6'd32; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check_vec("pre_reset_busy", int'(bus.busy), 1);
        nrst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        check_zero_outputs("midreset");
        bus.start = 1'b0;
        nrst = 1'b1;
        ndone = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.done || bus.busy) ndone++;
            @(negedge clk);
        end
        check_vec("midreset_idle", ndone, 0);

        // Start held high through the scan yields one done.
        @(negedge clk);
        bus.base_addr = '0; bus.count = 6'd4; bus.start = 1'b1;
        ndone = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check_vec("held_start_dones", ndone, 1);
        check_vec("held_start_data",  int'(bus.max_data), 9);
        check_vec("held_start_addr",  int'(bus.max_addr), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
